// File: rtl/bmem_burst_responder.sv
// Memory-side responder for the 4-beat x 64-bit burst bus: stores DEPTH 256-bit lines,
// absorbs write bursts and replays read bursts a fixed number of cycles after accept.
module bmem_burst_responder #(
    parameter int IDX_W   = 6,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bmem_addr,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic        bmem_ready,
    output logic [31:0] bmem_raddr,
    output logic [63:0] bmem_rdata,
    output logic        bmem_rvalid,
    output logic        proto_err
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam int WORDS = DEPTH * 4;
    localparam int LAT_W = $clog2(LATENCY) + 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_BURST,
        ST_RD_WAIT,
        ST_RD_BURST
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         beat_q, beat_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [26:0]        line_q, line_d;
    logic [26:0]        raddr_q, raddr_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d;
    logic [63:0]        rdata_q;

    // Storage is one 64-bit word per beat: word address = {line index, beat}.
    logic [63:0]        mem [WORDS];
    logic               wr_en;
    logic [IDX_W+1:0]   wr_addr;
    logic               rd_en;
    logic [IDX_W+1:0]   rd_addr;

    logic [IDX_W-1:0]   addr_idx;
    logic               unused_addr_bits;

    assign addr_idx         = bmem_addr[5 +: IDX_W];
    assign unused_addr_bits = ^bmem_addr[4:0];

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        line_d  = line_q;
        raddr_d = raddr_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_addr = {line_q[IDX_W-1:0], beat_q};
        rd_en   = 1'b0;
        rd_addr = {raddr_q[IDX_W-1:0], beat_q};

        if (!ready_q && (bmem_read || bmem_write)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (ready_q && bmem_read) begin
                    // A simultaneous write beat loses to the read and is dropped.
                    if (bmem_write) begin
                        err_d = 1'b1;
                    end
                    raddr_d = bmem_addr[31:5];
                    beat_d  = 2'd0;
                    lat_d   = '0;
                    if (LATENCY == 1) begin
                        state_d = ST_RD_BURST;
                        rd_en   = 1'b1;
                        rd_addr = {addr_idx, 2'b00};
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end else if (ready_q && bmem_write) begin
                    wr_en   = 1'b1;
                    wr_addr = {addr_idx, 2'b00};
                    line_d  = bmem_addr[31:5];
                    beat_d  = 2'd1;
                    state_d = ST_WR_BURST;
                end
            end
            ST_WR_BURST: begin
                if (bmem_read) begin
                    err_d = 1'b1;
                end
                if (bmem_write) begin
                    wr_en = 1'b1;
                    if (bmem_addr[31:5] != line_q) begin
                        err_d = 1'b1;
                    end
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    state_d = ST_RD_BURST;
                    rd_en   = 1'b1;
                    rd_addr = {raddr_q[IDX_W-1:0], 2'b00};
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ST_RD_BURST: begin
                // rdata_q already holds beat_q; prefetch the next beat for the next cycle.
                if (beat_q == 2'd3) begin
                    state_d = ST_IDLE;
                    beat_d  = 2'd0;
                end else begin
                    beat_d  = beat_q + 2'd1;
                    rd_en   = 1'b1;
                    rd_addr = {raddr_q[IDX_W-1:0], beat_q + 2'd1};
                end
            end
        endcase

        ready_d = (state_d == ST_IDLE) || (state_d == ST_WR_BURST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= 2'd0;
            lat_q   <= '0;
            line_q  <= '0;
            raddr_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            line_q  <= line_d;
            raddr_q <= raddr_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            if (rd_en) begin
                rdata_q <= mem[rd_addr];
            end
        end
    end

    // Line contents deliberately survive reset; wr_en is low while rst holds ready low.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= bmem_wdata;
        end
    end

    assign bmem_ready  = ready_q;
    assign bmem_raddr  = {raddr_q, 5'b0};
    assign bmem_rdata  = rdata_q;
    assign bmem_rvalid = (state_q == ST_RD_BURST);
    assign proto_err   = err_q;

endmodule

// File: tb/tb_bmem_burst_responder.sv
// Directed bench for bmem_burst_responder: reset, burst writes/reads, aliasing,
// read/write collision and reset during a read burst.
module tb_bmem_burst_responder;

    logic        clk;
    logic        rst;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;
    logic        proto_err;

    int n_cmp = 0;
    int n_mis = 0;

    bmem_burst_responder #(.IDX_W(6), .LATENCY(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid),
        .proto_err  (proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [255:0] LINE_A = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
                                       64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
    localparam logic [255:0] LINE_D = {64'hD3D3_1111_2222_3333, 64'hD2D2_4444_5555_6666,
                                       64'hD1D1_7777_8888_9999, 64'hD0D0_AAAA_BBBB_CCCC};
    localparam logic [255:0] LINE_B = {64'hB3B3_0000_0000_00B3, 64'hB2B2_0000_0000_00B2,
                                       64'hB1B1_0000_0000_00B1, 64'hB0B0_0000_0000_00B0};
    localparam logic [255:0] LINE_C = {64'hC3C3_0000_0000_00C3, 64'hC2C2_0000_0000_00C2,
                                       64'hC1C1_0000_0000_00C1, 64'hC0C0_0000_0000_00C0};

    // Drives a 4-beat write burst; gap idle cycles are inserted between beats.
    task automatic wr_burst(input logic [31:0] a, input logic [255:0] line, input int gap);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            bmem_write = 1'b1;
            bmem_addr  = a;
            bmem_wdata = line[64*k +: 64];
            @(negedge clk);
            if (gap > 0 && k < 3) begin
                bmem_write = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        bmem_write = 1'b0;
    endtask

    // Issues one read (optionally with write also high) and records the returned burst.
    // j counts edges after the accept edge; a beat seen at j was registered by edge T+j.
    task automatic rd_capture(input logic [31:0] a, input logic with_write,
                              output logic [255:0] beats, output logic [31:0] ra,
                              output int first_j, output int last_j, output int nbeats,
                              output logic rdy_after);
        beats = '0; ra = '0; first_j = -1; last_j = -1; nbeats = 0; rdy_after = 1'bx;
        @(negedge clk);
        bmem_read  = 1'b1;
        bmem_write = with_write;
        bmem_addr  = a;
        bmem_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        for (int j = 0; j < 16; j++) begin
            if (j > 0) @(negedge clk);
            if (bmem_rvalid === 1'b1) begin
                if (nbeats < 4) beats[64*nbeats +: 64] = bmem_rdata;
                if (first_j < 0) first_j = j;
                last_j = j;
                ra = bmem_raddr;
                nbeats++;
            end
            if (first_j >= 0 && j == first_j + 4) rdy_after = bmem_ready;
        end
    endtask

    task automatic test_reset();
        #7;
        n_cmp++; if (bmem_ready !== 1'b0) begin $display("FAIL reset_ready: got %b want 0", bmem_ready); n_mis++; end
        n_cmp++; if (bmem_rvalid !== 1'b0) begin $display("FAIL reset_rvalid: got %b want 0", bmem_rvalid); n_mis++; end
        n_cmp++; if (proto_err !== 1'b0) begin $display("FAIL reset_err: got %b want 0", proto_err); n_mis++; end
        n_cmp++; if (bmem_rdata !== 64'h0) begin $display("FAIL reset_rdata: got %h want 0", bmem_rdata); n_mis++; end
        n_cmp++; if (bmem_raddr !== 32'h0) begin $display("FAIL reset_raddr: got %h want 0", bmem_raddr); n_mis++; end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bmem_ready !== 1'b1) begin $display("FAIL ready_after_release: got %b want 1", bmem_ready); n_mis++; end
        // Start a read, then poke read while ready is low to raise proto_err.
        bmem_read = 1'b1; bmem_addr = 32'h0;
        @(negedge clk);
        bmem_read = 1'b0;
        n_cmp++; if (bmem_ready !== 1'b0) begin $display("FAIL ready_after_accept: got %b want 0", bmem_ready); n_mis++; end
        bmem_read = 1'b1;
        @(negedge clk);
        bmem_read = 1'b0;
        n_cmp++; if (proto_err !== 1'b1) begin $display("FAIL err_read_not_ready: got %b want 1", proto_err); n_mis++; end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (proto_err !== 1'b0) begin $display("FAIL async_rst_err: got %b want 0", proto_err); n_mis++; end
        n_cmp++; if (bmem_ready !== 1'b0) begin $display("FAIL async_rst_ready: got %b want 0", bmem_ready); n_mis++; end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bmem_ready !== 1'b1) begin $display("FAIL ready_after_release2: got %b want 1", bmem_ready); n_mis++; end
    endtask

    task automatic test_back_to_back();
        logic [255:0] got; logic [31:0] ra; int fj, lj, nb; logic rdy;
        wr_burst(32'h0000_1000, LINE_A, 0);
        rd_capture(32'h0000_1000, 1'b0, got, ra, fj, lj, nb, rdy);
        n_cmp++; if (fj !== 3) begin $display("FAIL b2b_first_rvalid: got edge %0d want 3", fj); n_mis++; end
        n_cmp++; if (nb !== 4 || lj !== 6) begin $display("FAIL b2b_beats: got %0d beats ending %0d want 4 ending 6", nb, lj); n_mis++; end
        n_cmp++; if (got !== LINE_A) begin $display("FAIL b2b_data: got %h want %h", got, LINE_A); n_mis++; end
        n_cmp++; if (ra !== 32'h0000_1000) begin $display("FAIL b2b_raddr: got %h want 00001000", ra); n_mis++; end
        n_cmp++; if (rdy !== 1'b1) begin $display("FAIL b2b_ready_after: got %b want 1", rdy); n_mis++; end
    endtask

    task automatic test_gapped_write();
        logic [255:0] got; logic [31:0] ra; int fj, lj, nb; logic rdy;
        wr_burst(32'h0000_1000, LINE_D, 2);
        rd_capture(32'h0000_101F, 1'b0, got, ra, fj, lj, nb, rdy);
        n_cmp++; if (got !== LINE_D) begin $display("FAIL gap_data: got %h want %h", got, LINE_D); n_mis++; end
        n_cmp++; if (ra !== 32'h0000_1000) begin $display("FAIL gap_raddr: got %h want 00001000", ra); n_mis++; end
        n_cmp++; if (nb !== 4 || fj !== 3) begin $display("FAIL gap_beats: got %0d from %0d want 4 from 3", nb, fj); n_mis++; end
        n_cmp++; if (proto_err !== 1'b0) begin $display("FAIL gap_err: got %b want 0", proto_err); n_mis++; end
    endtask

    task automatic test_alias();
        logic [255:0] got; logic [31:0] ra; int fj, lj, nb; logic rdy;
        wr_burst(32'h0000_0040, LINE_B, 0);
        wr_burst(32'h0000_0840, LINE_C, 1);
        rd_capture(32'h0000_0040, 1'b0, got, ra, fj, lj, nb, rdy);
        n_cmp++; if (got !== LINE_C) begin $display("FAIL alias_data: got %h want %h", got, LINE_C); n_mis++; end
        n_cmp++; if (ra !== 32'h0000_0040) begin $display("FAIL alias_raddr: got %h want 00000040", ra); n_mis++; end
        rd_capture(32'h0000_1000, 1'b0, got, ra, fj, lj, nb, rdy);
        n_cmp++; if (got !== LINE_D) begin $display("FAIL alias_other_line: got %h want %h", got, LINE_D); n_mis++; end
    endtask

    task automatic test_collision();
        logic [255:0] got; logic [31:0] ra; int fj, lj, nb; logic rdy;
        rd_capture(32'h0000_1000, 1'b1, got, ra, fj, lj, nb, rdy);
        n_cmp++; if (got !== LINE_D || nb !== 4) begin $display("FAIL coll_data: got %h (%0d beats) want %h", got, nb, LINE_D); n_mis++; end
        n_cmp++; if (proto_err !== 1'b1) begin $display("FAIL coll_err: got %b want 1", proto_err); n_mis++; end
        rd_capture(32'h0000_1000, 1'b0, got, ra, fj, lj, nb, rdy);
        n_cmp++; if (got !== LINE_D) begin $display("FAIL coll_line_kept: got %h want %h", got, LINE_D); n_mis++; end
        n_cmp++; if (proto_err !== 1'b1) begin $display("FAIL coll_err_sticky: got %b want 1", proto_err); n_mis++; end
    endtask

    task automatic test_reset_mid_burst();
        logic [255:0] got; logic [31:0] ra; int fj, lj, nb; logic rdy;
        int seen;
        seen = 0;
        @(negedge clk);
        bmem_read = 1'b1; bmem_addr = 32'h0000_1000;
        @(negedge clk);
        bmem_read = 1'b0;
        for (int j = 0; j < 16 && seen < 2; j++) begin
            if (j > 0) @(negedge clk);
            if (bmem_rvalid === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 2 || bmem_rdata !== LINE_D[127:64]) begin
            $display("FAIL mid_beat1: got %0d beats rdata %h want 2 beats rdata %h", seen, bmem_rdata, LINE_D[127:64]); n_mis++;
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bmem_rvalid !== 1'b0) begin $display("FAIL mid_rst_rvalid: got %b want 0", bmem_rvalid); n_mis++; end
        n_cmp++; if (proto_err !== 1'b0) begin $display("FAIL mid_rst_err: got %b want 0", proto_err); n_mis++; end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd_capture(32'h0000_1000, 1'b0, got, ra, fj, lj, nb, rdy);
        n_cmp++; if (got !== LINE_D || nb !== 4) begin $display("FAIL mid_reread: got %h (%0d beats) want %h", got, nb, LINE_D); n_mis++; end
        n_cmp++; if (fj !== 3) begin $display("FAIL mid_reread_latency: got edge %0d want 3", fj); n_mis++; end
    endtask

    initial begin
        rst = 1'b1;
        bmem_addr = '0; bmem_read = 1'b0; bmem_write = 1'b0; bmem_wdata = '0;
        test_reset();
        test_back_to_back();
        test_gapped_write();
        test_alias();
        test_collision();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
